// File: rtl/systolic_sequencer.sv
// rtl/systolic_sequencer.sv - job sequencer: operand skew, flush/wait timing, drain framing
module systolic_sequencer #(
  parameter int SYS_ARRAY_SIZE     = 4,
  parameter int DATA_WIDTH         = 16,
  parameter int DRAIN_CHANNEL_SIZE = 2,
  parameter int K_MAX              = 256,
  parameter int DRAIN_WAIT         = 6,
  localparam int N  = SYS_ARRAY_SIZE,
  localparam int DW = DATA_WIDTH,
  localparam int DC = DRAIN_CHANNEL_SIZE,
  localparam int KW = $clog2(K_MAX + 1),
  localparam int IW = $clog2(2 * N)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_valid_i,
  output logic            start_ready_o,
  input  logic [KW-1:0]   k_len_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [N*DW-1:0] a_col_i,
  input  logic [N*DW-1:0] b_row_i,
  output logic [N*DW-1:0] a_data_o,
  output logic [N-1:0]    a_valid_o,
  output logic [N-1:0]    a_last_o,
  output logic [N*DW-1:0] b_data_o,
  output logic [N-1:0]    b_valid_o,
  output logic [N-1:0]    b_last_o,
  input  logic [DC*DW-1:0] c_i,
  output logic            res_valid_o,
  output logic [DC*DW-1:0] res_data_o,
  output logic [IW-1:0]   res_idx_o,
  output logic            res_last_o,
  output logic            busy_o,
  output logic            done_o
);

  localparam int CMAX = (N > DRAIN_WAIT) ? N : DRAIN_WAIT;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FEED, S_FLUSH, S_WAIT, S_DRAIN, S_DONE_ZERO
  } state_t;

  state_t        state, state_nxt;
  logic [KW-1:0] k_len, kcnt, k_sat;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic          start_fire, beat_fire, beat_last;

  assign start_fire = start_valid_i && (state == S_IDLE);
  assign beat_fire  = in_valid_i && (state == S_FEED);
  assign beat_last  = beat_fire && (kcnt == k_len - KW'(1));
  // Out-of-contract lengths clamp instead of wrapping.
  assign k_sat      = (k_len_i > KW'(K_MAX)) ? KW'(K_MAX) : k_len_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= S_IDLE;
      k_len <= '0;
      kcnt  <= '0;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      if (start_fire) begin
        k_len <= k_sat;
        kcnt  <= '0;
      end else if (beat_fire) begin
        kcnt <= kcnt + KW'(1);
      end
      if (state != state_nxt)
        cnt <= '0;
      else if (state == S_FLUSH || state == S_WAIT)
        cnt <= cnt + CW'(1);
      if (state == S_DRAIN)
        idx <= (state_nxt == S_DRAIN) ? idx + IW'(1) : '0;
    end
  end

  always_comb begin
    state_nxt     = state;
    start_ready_o = 1'b0;
    in_ready_o    = 1'b0;
    busy_o        = 1'b1;
    res_valid_o   = 1'b0;
    res_last_o    = 1'b0;
    done_o        = 1'b0;
    case (state)
      S_IDLE: begin
        start_ready_o = 1'b1;
        busy_o        = 1'b0;
        if (start_fire)
          state_nxt = (k_sat == '0) ? S_DONE_ZERO : S_FEED;
      end
      S_FEED: begin
        in_ready_o = 1'b1;
        if (beat_last)
          state_nxt = S_FLUSH;
      end
      S_FLUSH: if (cnt == CW'(N - 1)) state_nxt = S_WAIT;
      S_WAIT:  if (cnt == CW'(DRAIN_WAIT - 1)) state_nxt = S_DRAIN;
      S_DRAIN: begin
        res_valid_o = 1'b1;
        if (idx == IW'(2 * N - 1)) begin
          res_last_o = 1'b1;
          done_o     = 1'b1;
          state_nxt  = S_IDLE;
        end
      end
      S_DONE_ZERO: begin
        done_o    = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    res_data_o = res_valid_o ? c_i : '0;
    res_idx_o  = res_valid_o ? idx : '0;
  end

  // Lane i is i+1 registers deep; non-accepted cycles enter as zero bubbles.
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [DW-1:0] a_q [0:i];
    logic [DW-1:0] b_q [0:i];
    logic          v_q [0:i];
    logic          l_q [0:i];

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        for (int s = 0; s <= i; s++) begin
          a_q[s] <= '0;
          b_q[s] <= '0;
          v_q[s] <= 1'b0;
          l_q[s] <= 1'b0;
        end
      end else begin
        a_q[0] <= beat_fire ? a_col_i[i*DW +: DW] : '0;
        b_q[0] <= beat_fire ? b_row_i[i*DW +: DW] : '0;
        v_q[0] <= beat_fire;
        l_q[0] <= beat_last;
        for (int s = 1; s <= i; s++) begin
          a_q[s] <= a_q[s-1];
          b_q[s] <= b_q[s-1];
          v_q[s] <= v_q[s-1];
          l_q[s] <= l_q[s-1];
        end
      end
    end

    assign a_data_o[i*DW +: DW] = a_q[i];
    assign b_data_o[i*DW +: DW] = b_q[i];
    assign a_valid_o[i]         = v_q[i];
    assign b_valid_o[i]         = v_q[i];
    assign a_last_o[i]          = l_q[i];
    assign b_last_o[i]          = l_q[i];
  end

endmodule

// File: tb/tb_systolic_sequencer.sv
// tb/tb_systolic_sequencer.sv - scoreboard bench for systolic_sequencer with a behavioural array model
module tb_systolic_sequencer;
  localparam int N = 4, DW = 16, DC = 2, KMAX = 256, DWAIT = 6;
  localparam int KW = $clog2(KMAX + 1), IW = $clog2(2 * N);

  logic clk = 1'b0;
  logic rst, start_valid, start_ready, in_valid, in_ready;
  logic [KW-1:0] k_len;
  logic [N*DW-1:0] a_col, b_row, a_data, b_data;
  logic [N-1:0] a_valid, a_last, b_valid, b_last;
  logic [DC*DW-1:0] c_in = '0;
  logic [DC*DW-1:0] res_data;
  logic res_valid, res_last, busy, done;
  logic [IW-1:0] res_idx;

  int n_cmp = 0, n_bad = 0, mode = 1;
  logic [35:0] sb [$];
  logic [31:0] ident_words [8] = '{32'h0002_0001, 32'h0004_0003, 32'h0006_0005, 32'h0008_0007,
                                   32'h000a_0009, 32'h000c_000b, 32'h000e_000d, 32'h0010_000f};

  always #5 clk = ~clk;

  systolic_sequencer #(.SYS_ARRAY_SIZE(N), .DATA_WIDTH(DW), .DRAIN_CHANNEL_SIZE(DC),
                       .K_MAX(KMAX), .DRAIN_WAIT(DWAIT)) dut (
    .clk_i(clk), .rst_i(rst), .start_valid_i(start_valid), .start_ready_o(start_ready),
    .k_len_i(k_len), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .a_col_i(a_col), .b_row_i(b_row), .a_data_o(a_data), .a_valid_o(a_valid), .a_last_o(a_last),
    .b_data_o(b_data), .b_valid_o(b_valid), .b_last_o(b_last), .c_i(c_in),
    .res_valid_o(res_valid), .res_data_o(res_data), .res_idx_o(res_idx), .res_last_o(res_last),
    .busy_o(busy), .done_o(done));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] a_elem(int k, int i);
    if (mode == 0) return (k == i) ? 16'd1 : 16'd0;
    return 16'((k * 3 + i + 1) % 16);
  endfunction

  function automatic logic [15:0] b_elem(int k, int j);
    if (mode == 0) return 16'(4 * k + j + 1);
    return 16'((k + 2 * j + 5) % 16);
  endfunction

  function automatic logic [35:0] exp_word(int w, int ke);
    logic [15:0] c0, c1;
    int r;
    r = w / 2; c0 = '0; c1 = '0;
    if (mode == 0) return {3'(w), ident_words[w], 1'(w == 2 * N - 1)};
    for (int k = 0; k < ke; k++) begin
      c0 = c0 + 16'(a_elem(k, r) * b_elem(k, 2 * (w % 2)));
      c1 = c1 + 16'(a_elem(k, r) * b_elem(k, 2 * (w % 2) + 1));
    end
    return {3'(w), c1, c0, 1'(w == 2 * N - 1)};
  endfunction

  // Index of the beat accepted in job cycle c, or -1 for none.
  function automatic int beat_at(int c, int gap, int t);
    if (c < 1 || c > t || c == gap) return -1;
    return c - 1 - ((gap > 0 && c > gap) ? 1 : 0);
  endfunction

  function automatic logic [21:0] ctl();
    return {start_ready, in_ready, busy, done, res_valid, res_last, a_valid, a_last, b_valid, b_last};
  endfunction

  // Called at one cycle's start (#1 after posedge) with the DUT in IDLE.
  task automatic run_job(input int k_in, input int gap, input bit hold, input int next_k);
    int ke, t, tend, bi, bj;
    logic [N-1:0] av, al;
    logic ir, rv, dn;
    logic [63:0] ea, eb;
    ke = (k_in > KMAX) ? KMAX : k_in;
    t = (ke == 0) ? 0 : ke + ((gap > 0) ? 1 : 0);
    tend = (ke == 0) ? 1 : t + 3 * N + DWAIT;
    start_valid = 1'b1;
    k_len = KW'(k_in);
    @(negedge clk);
    check($sformatf("idle_ctl k%0d", k_in), 64'(ctl()), 64'({1'b1, 21'b0}));
    if (ke > 0)
      for (int w = 0; w < 2 * N; w++) sb.push_back(exp_word(w, ke));
    @(posedge clk); #1;
    start_valid = hold;
    k_len = KW'(next_k);
    for (int c = 1; c <= tend; c++) begin
      bi = beat_at(c, gap, t);
      in_valid = (bi >= 0);
      for (int i = 0; i < N; i++) begin
        a_col[i*16 +: 16] = (bi >= 0) ? a_elem(bi, i) : 16'($urandom);
        b_row[i*16 +: 16] = (bi >= 0) ? b_elem(bi, i) : 16'($urandom);
      end
      @(negedge clk);
      ea = '0; eb = '0;
      for (int i = 0; i < N; i++) begin
        bj = beat_at(c - 1 - i, gap, t);
        av[i] = (bj >= 0);
        al[i] = (ke > 0) && (c - 1 - i == t);
        if (bj >= 0) begin
          ea[i*16 +: 16] = a_elem(bj, i);
          eb[i*16 +: 16] = b_elem(bj, i);
        end
      end
      ir = (ke > 0) && (c <= t);
      rv = (ke > 0) && (c >= t + N + DWAIT + 1);
      dn = (c == tend);
      check($sformatf("ctl k%0d c%0d", k_in, c), 64'(ctl()),
            64'({1'b0, ir, 1'b1, dn, rv, dn && ke > 0, av, al, av, al}));
      check($sformatf("a_data k%0d c%0d", k_in, c), a_data, ea);
      check($sformatf("b_data k%0d c%0d", k_in, c), b_data, eb);
      if (!rv) check($sformatf("res_data_idle k%0d c%0d", k_in, c), 64'(res_data), 64'(0));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  // Behavioural array: records lane beats, then drains C row-major two elements per word.
  logic [15:0] acap [N][300];
  logic [15:0] bcap [N][300];
  int acnt [N];
  int bcnt [N];
  logic [15:0] cmat [N][N];
  always @(posedge clk) begin
    if (start_valid && start_ready)
      for (int i = 0; i < N; i++) begin acnt[i] = 0; bcnt[i] = 0; end
    for (int i = 0; i < N; i++) begin
      if (a_valid[i] && acnt[i] < 300) begin acap[i][acnt[i]] = a_data[i*16 +: 16]; acnt[i]++; end
      if (b_valid[i] && bcnt[i] < 300) begin bcap[i][bcnt[i]] = b_data[i*16 +: 16]; bcnt[i]++; end
    end
    if (a_valid[N-1] && a_last[N-1]) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          cmat[i][j] = '0;
          for (int k = 0; k < acnt[i] && k < bcnt[j]; k++)
            cmat[i][j] = cmat[i][j] + 16'(acap[i][k] * bcap[j][k]);
        end
      repeat (DWAIT) @(posedge clk);
      for (int w = 0; w < 2 * N; w++) begin
        #1 c_in = {cmat[w/2][2*(w%2)+1], cmat[w/2][2*(w%2)]};
        @(posedge clk);
      end
      #1 c_in = '0;
    end
  end

  always @(negedge clk) begin
    if (res_valid) begin
      if (sb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL res_word: got idx %0d data %h with nothing expected", res_idx, res_data);
      end else begin
        check("res_word", 64'({res_idx, res_data, res_last}), 64'(sb.pop_front()));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got %0d compared", n_cmp);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start_valid = 1'b0; k_len = '0; in_valid = 1'b0; a_col = '0; b_row = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ctl", 64'(ctl()), 64'({1'b1, 21'b0}));
    check("reset_a_data", a_data, 64'(0));
    check("reset_res", 64'({res_data, res_idx}), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    start_valid = 1'b1; k_len = KW'(5);
    @(posedge clk); #1;
    start_valid = 1'b0;
    for (int b = 0; b < 2; b++) begin
      in_valid = 1'b1;
      for (int i = 0; i < N; i++) begin
        a_col[i*16 +: 16] = a_elem(b, i);
        b_row[i*16 +: 16] = b_elem(b, i);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_ctl", 64'(ctl()), 64'({1'b1, 21'b0}));
    check("abort_a_data", a_data, 64'(0));
    check("abort_b_data", b_data, 64'(0));
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check($sformatf("abort_quiet c%0d", c), 64'(ctl()), 64'({1'b1, 21'b0}));
    end
    @(posedge clk); #1;

    run_job(3, 0, 1'b0, 0);
    run_job(4, 2, 1'b0, 0);
    run_job(0, 0, 1'b0, 0);
    run_job(2, 0, 1'b1, 300);
    run_job(300, 0, 1'b0, 0);
    mode = 0;
    run_job(4, 0, 1'b0, 0);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(sb.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
